// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C byte-register target: FSM states and ACK/NACK line levels.

package i2c_target_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StPtr,
      StPtrAck,
      StWr,
      StWrAck,
      StRd,
      StRdAck,
      StWaitStop
   } state_e;

   localparam logic AckBit  = 1'b0;
   localparam logic NackBit = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchroniser followed by a glitch filter: the output takes a new level only after
// FILT_LEN consecutive synchronised samples agree on it.

module i2c_in_filter #(
   parameter int unsigned FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   localparam int unsigned CW = $clog2(FILT_LEN + 1);

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CW'(FILT_LEN - 1)) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Preset high so an idle bus is seen right out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign q_o = filt_q;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target exposing DEPTH byte registers behind an auto-incrementing pointer,
// with a combinational debug read port into the register array.

module i2c_target_mem
   import i2c_target_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR = 7'h50,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i2c_scl_i,
   input  logic                       i2c_sda_i,
   output logic                       i2c_scl_o,
   output logic                       i2c_scl_t,
   output logic                       i2c_sda_o,
   output logic                       i2c_sda_t,
   output logic                       busy,
   output logic                       wr_stb,
   output logic [$clog2(DEPTH)-1:0]   wr_ptr,
   input  logic [$clog2(DEPTH)-1:0]   dbg_addr,
   output logic [7:0]                 dbg_data
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic          scl_f, sda_f, scl_prev_q, sda_prev_q;
   logic          scl_rise, scl_fall, start_det, stop_det;
   state_e        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d, rx_byte, nxt_byte;
   logic [PW-1:0] ptr_q, ptr_d, ptr_inc, wr_ptr_q, wr_ptr_d;
   logic          sda_t_q, sda_t_d, busy_q, busy_d, wr_stb_q, wr_stb_d, mack_q, mack_d;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];

   i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (.clk(clk), .rst(rst), .d_i(i2c_scl_i), .q_o(scl_f));
   i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (.clk(clk), .rst(rst), .d_i(i2c_sda_i), .q_o(sda_f));

   assign scl_rise  = scl_f & ~scl_prev_q;
   assign scl_fall  = ~scl_f & scl_prev_q;
   assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
   assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
   assign rx_byte   = {shift_q[6:0], sda_f};
   assign ptr_inc   = ptr_q + PW'(1);
   assign nxt_byte  = mem_q[ptr_inc];

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      sda_t_d   = sda_t_q;
      busy_d    = busy_q;
      wr_stb_d  = 1'b0;
      wr_ptr_d  = wr_ptr_q;
      mack_d    = mack_q;
      mem_d     = mem_q;
      if (stop_det) begin
         state_d   = StIdle;
         sda_t_d   = NackBit;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (start_det) begin
         state_d   = StAddr;
         sda_t_d   = NackBit;
         bit_cnt_d = '0;
      end else begin
         unique case (state_q)
            StAddr, StPtr, StWr: begin
               if (scl_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == StAddr) begin
                        busy_d  = (rx_byte[7:1] == DEV_ADDR);
                        state_d = (rx_byte[7:1] == DEV_ADDR) ? StAddrAck : StWaitStop;
                     end else if (state_q == StPtr) begin
                        ptr_d   = rx_byte[PW-1:0];
                        state_d = StPtrAck;
                     end else begin
                        mem_d[ptr_q] = rx_byte;
                        wr_stb_d     = 1'b1;
                        wr_ptr_d     = ptr_q;
                        state_d      = StWrAck;
                     end
                  end
               end
            end
            // First SCL fall drives the ACK, the next one releases it and moves on.
            StAddrAck, StPtrAck, StWrAck: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     sda_t_d   = AckBit;
                     bit_cnt_d = 3'd1;
                  end else begin
                     sda_t_d   = NackBit;
                     bit_cnt_d = '0;
                     if (state_q == StAddrAck && shift_q[0]) begin
                        sda_t_d = mem_q[ptr_q][7];
                        shift_d = {mem_q[ptr_q][6:0], 1'b1};
                        state_d = StRd;
                     end else if (state_q == StWrAck) begin
                        ptr_d   = ptr_inc;
                        state_d = StWr;
                     end else begin
                        state_d = (state_q == StAddrAck) ? StPtr : StWr;
                     end
                  end
               end
            end
            StRd: begin
               if (scl_fall) begin
                  sda_t_d = shift_q[7];
                  shift_d = {shift_q[6:0], 1'b1};
               end else if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_d = StRdAck;
               end
            end
            // Phases: 0 release on fall, 1 sample master ACK on rise, 2 act on fall.
            StRdAck: begin
               if (scl_fall && bit_cnt_q == 3'd0) begin
                  sda_t_d   = NackBit;
                  bit_cnt_d = 3'd1;
               end else if (scl_rise && bit_cnt_q == 3'd1) begin
                  mack_d    = sda_f;
                  bit_cnt_d = 3'd2;
               end else if (scl_fall && bit_cnt_q == 3'd2) begin
                  ptr_d     = ptr_inc;
                  bit_cnt_d = '0;
                  if (mack_q == AckBit) begin
                     sda_t_d = nxt_byte[7];
                     shift_d = {nxt_byte[6:0], 1'b1};
                     state_d = StRd;
                  end else begin
                     state_d = StWaitStop;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ptr_q      <= '0;
         sda_t_q    <= 1'b1;
         busy_q     <= 1'b0;
         wr_stb_q   <= 1'b0;
         wr_ptr_q   <= '0;
         mack_q     <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         sda_t_q    <= sda_t_d;
         busy_q     <= busy_d;
         wr_stb_q   <= wr_stb_d;
         wr_ptr_q   <= wr_ptr_d;
         mack_q     <= mack_d;
         scl_prev_q <= scl_f;
         sda_prev_q <= sda_f;
         mem_q      <= mem_d;
      end
   end

   assign i2c_scl_o = 1'b0;
   assign i2c_scl_t = 1'b1;
   assign i2c_sda_o = 1'b0;
   assign i2c_sda_t = sda_t_q;
   assign busy      = busy_q;
   assign wr_stb    = wr_stb_q;
   assign wr_ptr    = wr_ptr_q;
   assign dbg_data  = mem_q[dbg_addr];

endmodule
